// File: rtl/pipe_stage_skid.sv
// One pipeline stage {npc, instr} with valid/ready handshake and a one-entry skid buffer.
// Optional perf counters (stall_cnt, bubble_cnt) are built only when PIPE_STAGE_SKID_PERF_EN is defined.
module pipe_stage_skid #(
    parameter int NPC_W          = 32,
    parameter int INSTR_W        = 32,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NPC_W-1:0]   in_npc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NPC_W-1:0]   out_npc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        bubble_cnt,
    output logic [1:0]         dbg_state_o
);

    // Handshake: a word moves on a cycle where valid and ready are both high at
    // the rising edge; valid never waits on ready, and in_ready is a pure decode
    // of registered state, so no combinational path runs from out_ready to in_ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NPC_W-1:0]   main_npc_q, main_npc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [NPC_W-1:0]   skid_npc_q, skid_npc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic               accept;
    logic               send;

    assign in_ready    = (state_q != FULL);
    assign out_valid   = (state_q != EMPTY);
    assign out_npc     = main_npc_q;
    assign out_instr   = main_instr_q;
    assign dbg_state_o = state_q;

    assign accept = in_valid & in_ready;
    assign send   = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        main_npc_d   = main_npc_q;
        main_instr_d = main_instr_q;
        skid_npc_d   = skid_npc_q;
        skid_instr_d = skid_instr_q;

        if (flush) begin
            // Redirect wins over any accept/send; the incoming word is dropped.
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                main_npc_d   = '0;
                main_instr_d = '0;
                skid_npc_d   = '0;
                skid_instr_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        main_npc_d   = in_npc;
                        main_instr_d = in_instr;
                    end
                end
                ONE: begin
                    if (accept && send) begin
                        main_npc_d   = in_npc;
                        main_instr_d = in_instr;
                    end else if (accept) begin
                        state_d      = FULL;
                        skid_npc_d   = in_npc;
                        skid_instr_d = in_instr;
                    end else if (send) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (send) begin
                        state_d      = ONE;
                        main_npc_d   = skid_npc_q;
                        main_instr_d = skid_instr_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= EMPTY;
            main_npc_q   <= '0;
            main_instr_q <= '0;
            skid_npc_q   <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            main_npc_q   <= main_npc_d;
            main_instr_q <= main_instr_d;
            skid_npc_q   <= skid_npc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] bubble_q, bubble_d;

    // A flush counts as one bubble only when it throws away a held word.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid && !out_ready) begin
            stall_d = stall_q + 32'd1;
        end
        if ((!out_valid && !flush) || (flush && out_valid)) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid: one clearing instance and one payload-holding instance.
module tb_pipe_stage_skid;

    localparam int NPC_W   = 32;
    localparam int INSTR_W = 32;

    logic               CLK;
    logic               nRST;

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [NPC_W-1:0]   in_npc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [NPC_W-1:0]   out_npc;
    logic [INSTR_W-1:0] out_instr;
    logic [31:0]        stall_cnt;
    logic [31:0]        bubble_cnt;
    logic [1:0]         dbg_state;

    logic               h_flush;
    logic               h_in_valid;
    logic               h_in_ready;
    logic [NPC_W-1:0]   h_in_npc;
    logic [INSTR_W-1:0] h_in_instr;
    logic               h_out_valid;
    logic               h_out_ready;
    logic [NPC_W-1:0]   h_out_npc;
    logic [INSTR_W-1:0] h_out_instr;
    logic [31:0]        h_stall_cnt;
    logic [31:0]        h_bubble_cnt;
    logic [1:0]         h_dbg_state;

    int vectors;
    int miscompares;

    pipe_stage_skid #(.NPC_W(NPC_W), .INSTR_W(INSTR_W), .CLEAR_ON_FLUSH(1)) u_dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_npc(in_npc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_npc(out_npc), .out_instr(out_instr),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .dbg_state_o(dbg_state)
    );

    pipe_stage_skid #(.NPC_W(NPC_W), .INSTR_W(INSTR_W), .CLEAR_ON_FLUSH(0)) u_dut_hold (
        .CLK(CLK), .nRST(nRST), .flush(h_flush),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_npc(h_in_npc), .in_instr(h_in_instr),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out_npc(h_out_npc), .out_instr(h_out_instr),
        .stall_cnt(h_stall_cnt), .bubble_cnt(h_bubble_cnt), .dbg_state_o(h_dbg_state)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one edge and land 1 time unit after it, away from the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_npc     = '0;
        in_instr   = '0;
        out_ready  = 1'b1;
        h_flush    = 1'b0;
        h_in_valid = 1'b0;
        h_in_npc   = '0;
        h_in_instr = '0;
        h_out_ready = 1'b1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        nRST = 1'b0;
        step();
        step();
        nRST = 1'b1;
    endtask

    task automatic drive_in(input logic v, input logic [NPC_W-1:0] npc, input logic [INSTR_W-1:0] instr);
        in_valid = v;
        in_npc   = npc;
        in_instr = instr;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        #3;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        vectors++; if (out_npc !== 32'h0) begin miscompares++; $display("FAIL reset_out_npc got %h exp 0", out_npc); end
        vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
        vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        vectors++; if (stall_cnt !== 32'h0) begin miscompares++; $display("FAIL reset_stall_cnt got %h exp 0", stall_cnt); end
        vectors++; if (bubble_cnt !== 32'h0) begin miscompares++; $display("FAIL reset_bubble_cnt got %h exp 0", bubble_cnt); end
        vectors++; if (h_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_h_out_valid got %0b exp 0", h_out_valid); end
        step();
        nRST = 1'b1;
        step();
    endtask

    task automatic test_stream();
        apply_reset();
        out_ready = 1'b1;
        drive_in(1'b1, 32'd4, 32'hA);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready0 got %0b exp 1", in_ready); end
        step();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_v1 got %0b exp 1", out_valid); end
        vectors++; if (out_npc !== 32'd4) begin miscompares++; $display("FAIL stream_npc1 got %0d exp 4", out_npc); end
        vectors++; if (out_instr !== 32'hA) begin miscompares++; $display("FAIL stream_instr1 got %h exp a", out_instr); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready1 got %0b exp 1", in_ready); end
        drive_in(1'b1, 32'd8, 32'hB);
        step();
        vectors++; if (out_npc !== 32'd8) begin miscompares++; $display("FAIL stream_npc2 got %0d exp 8", out_npc); end
        vectors++; if (out_instr !== 32'hB) begin miscompares++; $display("FAIL stream_instr2 got %h exp b", out_instr); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready2 got %0b exp 1", in_ready); end
        drive_in(1'b1, 32'd12, 32'hC);
        step();
        vectors++; if (out_npc !== 32'd12) begin miscompares++; $display("FAIL stream_npc3 got %0d exp 12", out_npc); end
        vectors++; if (out_instr !== 32'hC) begin miscompares++; $display("FAIL stream_instr3 got %h exp c", out_instr); end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_v3 got %0b exp 1", out_valid); end
        drive_in(1'b0, 32'd0, 32'h0);
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain got %0b exp 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready_end got %0b exp 1", in_ready); end
    endtask

    task automatic test_back_pressure();
        apply_reset();
        out_ready = 1'b0;
        drive_in(1'b1, 32'd4, 32'h14);
        step();
        vectors++; if (dbg_state !== 2'd1) begin miscompares++; $display("FAIL bp_state_one got %0d exp 1", dbg_state); end
        drive_in(1'b1, 32'd8, 32'h18);
        step();
        vectors++; if (dbg_state !== 2'd2) begin miscompares++; $display("FAIL bp_state_full got %0d exp 2", dbg_state); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_full got %0b exp 0", in_ready); end
        vectors++; if (out_npc !== 32'd4) begin miscompares++; $display("FAIL bp_hold_npc got %0d exp 4", out_npc); end
        drive_in(1'b1, 32'd12, 32'h1C);
        step();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_still got %0b exp 0", in_ready); end
        vectors++; if (out_npc !== 32'd4) begin miscompares++; $display("FAIL bp_stable_npc got %0d exp 4", out_npc); end
        vectors++; if (out_instr !== 32'h14) begin miscompares++; $display("FAIL bp_stable_instr got %h exp 14", out_instr); end
        out_ready = 1'b1;
        step();
        vectors++; if (out_npc !== 32'd8) begin miscompares++; $display("FAIL bp_out2_npc got %0d exp 8", out_npc); end
        vectors++; if (out_instr !== 32'h18) begin miscompares++; $display("FAIL bp_out2_instr got %h exp 18", out_instr); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_back got %0b exp 1", in_ready); end
        step();
        vectors++; if (out_npc !== 32'd12) begin miscompares++; $display("FAIL bp_out3_npc got %0d exp 12", out_npc); end
        vectors++; if (out_instr !== 32'h1C) begin miscompares++; $display("FAIL bp_out3_instr got %h exp 1c", out_instr); end
        drive_in(1'b0, 32'd0, 32'h0);
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_dup got %0b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        apply_reset();
        out_ready = 1'b0;
        drive_in(1'b1, 32'd20, 32'h20);
        step();
        drive_in(1'b1, 32'd24, 32'h24);
        step();
        vectors++; if (dbg_state !== 2'd2) begin miscompares++; $display("FAIL flush_pre_full got %0d exp 2", dbg_state); end
        drive_in(1'b1, 32'd16, 32'h16);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive_in(1'b0, 32'd0, 32'h0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid got %0b exp 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got %0b exp 1", in_ready); end
        vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL flush_clear_instr got %h exp 0", out_instr); end
        vectors++; if (out_npc !== 32'h0) begin miscompares++; $display("FAIL flush_clear_npc got %h exp 0", out_npc); end
        out_ready = 1'b1;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped_word got %0b exp 0", out_valid); end
        // The skid contents must be gone too: a fresh word follows directly.
        drive_in(1'b1, 32'd28, 32'h28);
        step();
        drive_in(1'b0, 32'd0, 32'h0);
        vectors++; if (out_npc !== 32'd28) begin miscompares++; $display("FAIL flush_next_npc got %0d exp 28", out_npc); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_next_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_flush_hold();
        apply_reset();
        h_out_ready = 1'b0;
        h_in_valid  = 1'b1;
        h_in_npc    = 32'h40;
        h_in_instr  = 32'h1234;
        step();
        vectors++; if (h_out_instr !== 32'h1234) begin miscompares++; $display("FAIL hold_load_instr got %h exp 1234", h_out_instr); end
        h_in_valid = 1'b0;
        h_flush    = 1'b1;
        step();
        h_flush = 1'b0;
        vectors++; if (h_out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_out_valid got %0b exp 0", h_out_valid); end
        vectors++; if (h_out_instr !== 32'h1234) begin miscompares++; $display("FAIL hold_out_instr got %h exp 1234", h_out_instr); end
        vectors++; if (h_out_npc !== 32'h40) begin miscompares++; $display("FAIL hold_out_npc got %h exp 40", h_out_npc); end
        vectors++; if (h_in_ready !== 1'b1) begin miscompares++; $display("FAIL hold_in_ready got %0b exp 1", h_in_ready); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        out_ready = 1'b0;
        drive_in(1'b1, 32'd4, 32'h4);
        step();
        drive_in(1'b1, 32'd8, 32'h8);
        step();
        drive_in(1'b0, 32'd0, 32'h0);
        vectors++; if (dbg_state !== 2'd2) begin miscompares++; $display("FAIL async_pre_full got %0d exp 2", dbg_state); end
        #2;
        nRST = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL async_out_valid got %0b exp 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL async_in_ready got %0b exp 1", in_ready); end
        vectors++; if (out_npc !== 32'h0) begin miscompares++; $display("FAIL async_out_npc got %h exp 0", out_npc); end
        #1;
        nRST = 1'b1;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL async_after got %0b exp 0", out_valid); end
    endtask

    task automatic test_perf();
        apply_reset();
        out_ready = 1'b0;
        drive_in(1'b1, 32'd4, 32'h4);
        step();
        drive_in(1'b0, 32'd0, 32'h0);
        for (int i = 0; i < 5; i++) step();
`ifdef PIPE_STAGE_SKID_PERF_EN
        vectors++; if (stall_cnt !== 32'd5) begin miscompares++; $display("FAIL perf_stall5 got %0d exp 5", stall_cnt); end
        vectors++; if (bubble_cnt !== 32'd1) begin miscompares++; $display("FAIL perf_bubble1 got %0d exp 1", bubble_cnt); end
        force u_dut.stall_q = 32'hFFFF_FFFF;
        #1;
        release u_dut.stall_q;
        step();
        vectors++; if (stall_cnt !== 32'h0) begin miscompares++; $display("FAIL perf_stall_wrap got %h exp 0", stall_cnt); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++; if (bubble_cnt !== 32'd2) begin miscompares++; $display("FAIL perf_bubble_flush got %0d exp 2", bubble_cnt); end
        vectors++; if (stall_cnt !== 32'd1) begin miscompares++; $display("FAIL perf_stall_flush got %0d exp 1", stall_cnt); end
        step();
        vectors++; if (bubble_cnt !== 32'd3) begin miscompares++; $display("FAIL perf_bubble_idle got %0d exp 3", bubble_cnt); end
`else
        vectors++; if (stall_cnt !== 32'h0) begin miscompares++; $display("FAIL perf_off_stall got %h exp 0", stall_cnt); end
        vectors++; if (bubble_cnt !== 32'h0) begin miscompares++; $display("FAIL perf_off_bubble got %h exp 0", bubble_cnt); end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nRST        = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_flush_hold();
        test_async_reset();
        test_perf();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
